// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 write sequencer.
// The POR_WAIT/INIT states exist only when LCD_AUTOINIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
`ifdef LCD_AUTOINIT_EN
        ,
        POR_WAIT,
        INIT
`endif
    } state_t;

    localparam int ON_BIT = 31;
    localparam int EN_BIT = 10;
    localparam int RS_BIT = 9;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear display and return home are the only slow instructions.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// lcd_driver_if: LCD register input plus LCD bus and status outputs.
// master is the register/software side, slave is the sequencer.
interface lcd_driver_if;

    logic [31:0] lcd_reg;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        busy;
    logic        overrun;

    modport master (
        output lcd_reg,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overrun
    );

    modport slave (
        input  lcd_reg,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overrun
    );

endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every sequencer phase.
// done is high in the cycle where a loaded count of L-1 has run out, i.e. L cycles after load.
module lcd_timer #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter bit          RESET_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic             running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= WIDTH'(RESET_VAL);
            running <= RESET_RUN;
        end else if (load) begin
            count   <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = running && (count == '0);

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: turns LCD register EN strobes into timed HD44780 bus writes with a one-entry pending slot.
// Define LCD_AUTOINIT_EN to add a power-on wait and the built-in init command sequence after reset.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned PULSE_CYC     = 25,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 82000,
    parameter int unsigned POR_CYC       = 1000000
) (
    input logic         i_clk,
    input logic         i_reset,
    lcd_driver_if.slave bus
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(HOLD_CYC, EXEC_CYC)),
                                            max_u(LONG_EXEC_CYC, POR_CYC));
    localparam int TW = $clog2(MAX_CYC + 1);

`ifdef LCD_AUTOINIT_EN
    localparam state_t      RESET_STATE = POR_WAIT;
    localparam int unsigned TMR_RST_VAL = POR_CYC - 1;
    localparam bit          TMR_RST_RUN = 1'b1;
`else
    localparam state_t      RESET_STATE = IDLE;
    localparam int unsigned TMR_RST_VAL = 0;
    localparam bit          TMR_RST_RUN = 1'b0;
`endif

    state_t        state, state_nxt;
    logic          prev_en, req, req_rs;
    logic [7:0]    req_data;
    logic [7:0]    data_q, launch_data;
    logic          rs_q, launch_rs, launch, on_q;
    logic          pend_valid, pend_valid_nxt, pend_rs, pend_rs_nxt;
    logic [7:0]    pend_data, pend_data_nxt;
    logic          overrun_q, overrun_set, free;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    logic          unused_bits;
`ifdef LCD_AUTOINIT_EN
    logic [2:0]    init_idx;
`endif

    assign req         = bus.lcd_reg[EN_BIT] & ~prev_en;
    assign req_rs      = bus.lcd_reg[RS_BIT];
    assign req_data    = bus.lcd_reg[7:0];
    assign unused_bits = ^{bus.lcd_reg[30:11], bus.lcd_reg[8]};

    lcd_timer #(
        .WIDTH    (TW),
        .RESET_VAL(TMR_RST_VAL),
        .RESET_RUN(TMR_RST_RUN)
    ) u_timer (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= RESET_STATE;
            prev_en    <= 1'b1;
            data_q     <= 8'h00;
            rs_q       <= 1'b0;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_data  <= 8'h00;
            overrun_q  <= 1'b0;
            on_q       <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_en    <= bus.lcd_reg[EN_BIT];
            pend_valid <= pend_valid_nxt;
            pend_rs    <= pend_rs_nxt;
            pend_data  <= pend_data_nxt;
            on_q       <= bus.lcd_reg[ON_BIT];
            if (launch) begin
                data_q <= launch_data;
                rs_q   <= launch_rs;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef LCD_AUTOINIT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            init_idx <= 3'd0;
        end else if (state == INIT) begin
            init_idx <= init_idx + 3'd1;
        end
    end
`endif

    // "free" marks the points where a new write may start: IDLE, or EXEC finishing with init done.
    always_comb begin
        state_nxt      = state;
        launch         = 1'b0;
        launch_rs      = rs_q;
        launch_data    = data_q;
        pend_valid_nxt = pend_valid;
        pend_rs_nxt    = pend_rs;
        pend_data_nxt  = pend_data;
        overrun_set    = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        free           = 1'b0;

        case (state)
            IDLE: free = 1'b1;
            SETUP: begin
                if (tmr_done) begin
                    state_nxt = PULSE;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_nxt = EXEC;
                    tmr_load  = 1'b1;
                    tmr_val   = is_long_cmd(rs_q, data_q) ? TW'(LONG_EXEC_CYC - 1) : TW'(EXEC_CYC - 1);
                end
            end
            EXEC: begin
                if (tmr_done) begin
`ifdef LCD_AUTOINIT_EN
                    if (init_idx < 3'(INIT_LEN)) state_nxt = INIT;
                    else
`endif
                    free = 1'b1;
                end
            end
`ifdef LCD_AUTOINIT_EN
            POR_WAIT: begin
                if (tmr_done) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                launch      = 1'b1;
                launch_rs   = 1'b0;
                launch_data = INIT_ROM[init_idx[1:0]];
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // A pending entry always goes before a request arriving in the same cycle, which refills the slot.
        if (free) begin
            state_nxt = IDLE;
            if (pend_valid) begin
                launch         = 1'b1;
                launch_rs      = pend_rs;
                launch_data    = pend_data;
                pend_valid_nxt = req;
                pend_rs_nxt    = req_rs;
                pend_data_nxt  = req_data;
            end else if (req) begin
                launch      = 1'b1;
                launch_rs   = req_rs;
                launch_data = req_data;
            end
        end else if (req) begin
            if (!pend_valid) begin
                pend_valid_nxt = 1'b1;
                pend_rs_nxt    = req_rs;
                pend_data_nxt  = req_data;
            end else begin
                overrun_set = 1'b1;
            end
        end

        if (launch) begin
            state_nxt = SETUP;
            tmr_load  = 1'b1;
            tmr_val   = TW'(SETUP_CYC - 1);
        end
    end

    assign bus.lcd_data = data_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = (state == PULSE);
    assign bus.lcd_on   = on_q;
    assign bus.busy     = (state != IDLE) | pend_valid;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: self-checking bench for lcd_driver, comparing against a transfer-timeline model every cycle.
// Build with LCD_AUTOINIT_EN defined to also check the power-on init sequence.
module tb_lcd_driver;

    localparam int S   = 2;
    localparam int P   = 3;
    localparam int H   = 2;
    localparam int E   = 5;
    localparam int L   = 20;
    localparam int POR = 10;

`ifdef LCD_AUTOINIT_EN
    localparam int   INIT_TOTAL = 4;
    localparam logic BUSY_RST   = 1'b1;
`else
    localparam int   INIT_TOTAL = 0;
    localparam logic BUSY_RST   = 1'b0;
`endif

    localparam logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] reg_val = 32'h0;
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;

    logic [8:0] pulses [$];
    logic       en_seen = 1'b0;

    // Model: one transfer timeline (start/end cycle), a one-entry queue, init bookkeeping.
    logic       m_active, m_prev, m_on, m_rs, m_overrun, m_gap;
    logic [7:0] m_data;
    int         m_start, m_end, m_por_left, m_init_idx;
    logic [8:0] m_q [$];

    lcd_driver_if bus ();
    assign bus.lcd_reg = reg_val;

    lcd_driver #(
        .SETUP_CYC    (S),
        .PULSE_CYC    (P),
        .HOLD_CYC     (H),
        .EXEC_CYC     (E),
        .LONG_EXEC_CYC(L),
        .POR_CYC      (POR)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int xfer_cycles(input logic rs, input logic [7:0] d);
        return S + P + H + ((!rs && d >= 8'h01 && d <= 8'h03) ? L : E);
    endfunction

    function automatic void model_launch(input logic [8:0] x);
        m_active = 1'b1;
        m_start  = cyc;
        m_end    = cyc + xfer_cycles(x[8], x[7:0]);
        m_rs     = x[8];
        m_data   = x[7:0];
    endfunction

    function automatic void model_step();
        logic       req, blocked;
        logic [8:0] rv, pv;
        if (!rst_n) begin
            m_active = 1'b0; m_prev = 1'b1; m_on = 1'b0; m_rs = 1'b0; m_data = 8'h00;
            m_overrun = 1'b0; m_gap = 1'b0; m_init_idx = 0; m_q.delete();
            m_por_left = (INIT_TOTAL > 0) ? POR : 0;
            return;
        end
        req     = reg_val[10] && !m_prev;
        m_prev  = reg_val[10];
        m_on    = reg_val[31];
        rv      = {reg_val[9], reg_val[7:0]};
        blocked = 1'b0;
        if (m_por_left > 0) begin
            m_por_left--;
            if (m_por_left == 0) m_gap = 1'b1;
            blocked = 1'b1;
        end else if (m_gap) begin
            m_gap = 1'b0;
            model_launch({1'b0, init_seq[m_init_idx]});
            m_init_idx++;
            blocked = 1'b1;
        end else if (m_active && cyc == m_end) begin
            m_active = 1'b0;
            if (m_init_idx < INIT_TOTAL) begin
                m_gap   = 1'b1;
                blocked = 1'b1;
            end
        end
        if (!m_active && !blocked) begin
            if (m_q.size() > 0) begin
                pv = m_q.pop_front();
                if (req) m_q.push_back(rv);
                model_launch(pv);
            end else if (req) begin
                model_launch(rv);
            end
        end else if (req) begin
            if (m_q.size() == 0) m_q.push_back(rv);
            else m_overrun = 1'b1;
        end
    endfunction

    // Per-cycle comparison against the model, plus capture of each EN pulse's RS/data.
    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        check_output("busy", 32'(bus.busy), 32'(m_active || m_por_left > 0 || m_gap || m_q.size() > 0));
        check_output("en", 32'(bus.lcd_en), 32'(m_active && (cyc - m_start) >= S && (cyc - m_start) < S + P));
        check_output("data", 32'(bus.lcd_data), 32'(m_data));
        check_output("rs", 32'(bus.lcd_rs), 32'(m_rs));
        check_output("rw", 32'(bus.lcd_rw), 32'h0);
        check_output("on", 32'(bus.lcd_on), 32'(m_on));
        check_output("overrun", 32'(bus.overrun), 32'(m_overrun));
        if (bus.lcd_en && !en_seen) pulses.push_back({bus.lcd_rs, bus.lcd_data});
        en_seen = bus.lcd_en;
    end

    task automatic apply_stimulus(input logic on, input logic en, input logic rs, input logic [7:0] d);
        @(negedge clk);
        reg_val     = 32'h0;
        reg_val[31] = on;
        reg_val[10] = en;
        reg_val[9]  = rs;
        reg_val[7:0] = d;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) break;
        end
        check_output("idle_timeout", 32'(bus.busy), 32'h0);
    endtask

    task automatic run_xfer(input logic [8:0] v, input int exp_busy);
        int   busy_len, en_first, en_len;
        logic held;
        busy_len = 0; en_first = -1; en_len = 0; held = 1'b1;
        apply_stimulus(1'b0, 1'b1, v[8], v[7:0]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
            if (!bus.busy) break;
            busy_len++;
            if (bus.lcd_en) begin
                if (en_first < 0) en_first = k;
                en_len++;
            end
            if (k < S + P + H && (bus.lcd_data !== v[7:0] || bus.lcd_rs !== v[8])) held = 1'b0;
            apply_stimulus(1'b0, 1'b0, v[8], v[7:0]);
            @(posedge clk);
            #1;
        end
        check_output($sformatf("busy_len_%03h", v), 32'(busy_len), 32'(exp_busy));
        check_output($sformatf("en_offset_%03h", v), 32'(en_first), 32'd2);
        check_output($sformatf("en_width_%03h", v), 32'(en_len), 32'd3);
        check_output($sformatf("held_%03h", v), 32'(held), 32'd1);
    endtask

    logic [8:0] vec      [7] = '{9'h141, 9'h001, 9'h080, 9'h002, 9'h000, 9'h003, 9'h101};
    int         vec_busy [7] = '{12, 27, 12, 27, 12, 27, 12};

    initial begin
        int cnt;
        reg_val = 32'h0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_output("rst_en", 32'(bus.lcd_en), 32'h0);
        check_output("rst_data", 32'(bus.lcd_data), 32'h0);
        check_output("rst_busy", 32'(bus.busy), 32'(BUSY_RST));
        check_output("rst_overrun", 32'(bus.overrun), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef LCD_AUTOINIT_EN
        wait_idle();
        check_output("init_count", 32'(pulses.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_output($sformatf("init_cmd%0d", i), 32'((pulses.size() > i) ? pulses[i] : 9'h1FF),
                         32'({1'b0, init_seq[i]}));
`else
        wait_idle();
`endif

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            run_xfer(vec[i], vec_busy[i]);
        end

        // Three strobes: first sent, second queued, third dropped.
        wait_idle();
        pulses.delete();
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b0, (k % 2) == 0, 1'b1, 8'h41 + 8'(k / 2));
            @(posedge clk);
            #1;
            if (bus.busy) cnt++;
        end
        for (int k = 0; k < 300 && bus.busy; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) cnt++;
        end
        check_output("burst_busy_len", 32'(cnt), 32'd24);
        check_output("burst_pulses", 32'(pulses.size()), 32'd2);
        check_output("burst_first", 32'((pulses.size() > 0) ? pulses[0] : 9'h000), 32'h141);
        check_output("burst_second", 32'((pulses.size() > 1) ? pulses[1] : 9'h000), 32'h142);
        check_output("burst_overrun", 32'(bus.overrun), 32'h1);

        // Reset in the middle of the EN pulse, with EN held high across release.
        wait_idle();
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h55);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.lcd_en) break;
        end
        check_output("en_before_reset", 32'(bus.lcd_en), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_en", 32'(bus.lcd_en), 32'h0);
        check_output("rst_mid_data", 32'(bus.lcd_data), 32'h0);
        check_output("rst_mid_rs", 32'(bus.lcd_rs), 32'h0);
        check_output("rst_mid_busy", 32'(bus.busy), 32'(BUSY_RST));
        check_output("rst_mid_overrun", 32'(bus.overrun), 32'h0);
        repeat (2) @(negedge clk);
        pulses.delete();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
`ifndef LCD_AUTOINIT_EN
        check_output("held_en_pulses", 32'(pulses.size()), 32'h0);
        check_output("held_en_busy", 32'(bus.busy), 32'h0);
`endif
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        wait_idle();

        // Power bit alone follows with one cycle of latency and never pulses EN.
        pulses.delete();
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        check_output("on_before_edge", 32'(bus.lcd_on), 32'h0);
        @(posedge clk);
        #1;
        check_output("on_after_edge", 32'(bus.lcd_on), 32'h1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check_output("off_after_edge", 32'(bus.lcd_on), 32'h0);
        check_output("on_no_pulse", 32'(pulses.size()), 32'h0);
        check_output("on_no_busy", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lcd_driver.md
# lcd_driver

Hardware write sequencer for the HD44780-compatible character LCD, sitting directly downstream of the core's memory-mapped LCD output register. It watches the 32-bit LCD register value, turns each software write strobe into a correctly timed LCD bus write (setup, enable pulse, hold, execution wait), and exposes a busy/overrun status. Software only sets data/RS and raises the EN bit; all bus timing is handled here.

## Interface
- `SETUP_CYC`, default 4: cycles from data/RS valid to EN rise (80 ns at 50 MHz).
- `PULSE_CYC`, default 25: EN high width in cycles.
- `HOLD_CYC`, default 4: cycles data/RS held after EN fall.
- `EXEC_CYC`, default 2000: post-write execution wait, normal commands and data.
- `LONG_EXEC_CYC`, default 82000: execution wait for clear/home commands.
- `POR_CYC`, default 1000000: power-on wait, used only with the auto-init feature.
- `i_clk` in 1: system clock (undivided board clock).
- `i_reset` in 1: asynchronous, active-low reset.
- `i_lcd_reg` in 32: LCD register value; [31] ON, [10] EN strobe, [9] RS, [8] RW (ignored), [7:0] DATA.
- `o_lcd_data` out 8: LCD data bus.
- `o_lcd_rs` out 1: register select.
- `o_lcd_rw` out 1: constant 0; the block is write-only.
- `o_lcd_en` out 1: LCD enable.
- `o_lcd_on` out 1: LCD power/backlight, registered copy of `i_lcd_reg[31]`.
- `o_busy` out 1: a write or wait is in progress, or a request is pending.
- `o_overrun` out 1: sticky; a request was dropped.

## Operation
- Request: `i_lcd_reg[10]` sampled 1 while its previous-cycle sample was 0. The request captures {RS=[9], DATA=[7:0]} from the same cycle.
- FSM states:
  - IDLE: on request, or if the pending slot is valid, go to SETUP.
  - SETUP (`SETUP_CYC`) -> PULSE (`PULSE_CYC`, EN=1) -> HOLD (`HOLD_CYC`) -> EXEC (n cycles) -> IDLE.
  - Data and RS are stable from SETUP entry through HOLD end.
- Long execution: RS=0 and DATA[7:2]=0 and DATA[1:0]≠0 (clear or home) uses n=`LONG_EXEC_CYC`. All other writes, including 0x00, use n=`EXEC_CYC`.
- Pending slot, one entry:
  - A request while not IDLE fills the slot if it is empty.
  - If the slot is full, the request is dropped and `o_overrun` is set.
- On leaving EXEC, a valid pending entry is taken and the FSM goes straight to SETUP; `o_busy` stays 1.
- Simultaneous events:
  - Request in the same cycle EXEC completes with the slot full: the pending entry launches and the new request refills the slot. No overrun.
  - Request in that cycle with the slot empty: the request launches directly.
- `o_busy` = (state≠IDLE) | pending valid.
- `o_overrun` is cleared only by reset.

## Timing
- Reset values: `o_lcd_data`=0, `o_lcd_rs`=0, `o_lcd_rw`=0, `o_lcd_en`=0, `o_lcd_on`=0, `o_overrun`=0, pending slot empty. `o_busy`=0, except 1 when auto-init is compiled in.
- Request detected at edge N: data, RS and `o_busy`=1 appear at N.
- EN rises at N+`SETUP_CYC` and falls at N+`SETUP_CYC`+`PULSE_CYC`.
- `o_busy` falls at N+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+n, if no pending entry.
- `o_lcd_on` has 1-cycle latency and is independent of the FSM.
- Reset asserted mid-transfer: EN drops immediately, the transfer is abandoned and the pending slot is cleared. No partial resumption.
- The edge detector's previous sample resets to 1, so an EN bit already high at reset release is not a request.

## Configuration
- `LCD_AUTOINIT_EN` defined:
  - After reset release, the FSM waits `POR_CYC` cycles with `o_busy`=1.
  - It then issues 0x38, 0x0C, 0x01, 0x06 with RS=0 through the normal SETUP..EXEC path; 0x01 uses the long wait.
  - User requests during init use the pending slot and overrun rules.
- `LCD_AUTOINIT_EN` undefined: reset goes straight to IDLE, and init is software's job.

## Structure
- Package `lcd_pkg`:
  - FSM state enum, including POR_WAIT and INIT, present only under the macro.
  - Register bit-position constants (ON=31, EN=10, RS=9).
  - The 4-entry init command ROM.
- Sub-module `lcd_timer`: loadable down-counter, width $clog2 of the largest cycle parameter, with a `done` pulse. One instance serves all FSM phases.

## Test plan
Bench parameters: SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=20, POR=10.
- Write RS=1, DATA=0x41 with EN 0->1 -> EN high for exactly 3 cycles starting 2 cycles after detect; data 0x41 and RS=1 held through HOLD; busy for 12 cycles.
- RS=0, DATA=0x01 -> busy for 27 cycles. RS=0, DATA=0x80 -> busy for 12 cycles.
- Three strobes 1 cycle apart (0x41, 0x42, 0x43) -> 0x41 then 0x42 sent back-to-back, busy never drops between them; 0x43 dropped; `o_overrun`=1.
- Reset pulled low during PULSE -> EN=0 and all outputs at reset values immediately; EN held high across reset release produces no transfer.
- With `LCD_AUTOINIT_EN`: reset release -> busy for 10 cycles, then exactly four EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS=0, then busy=0.
- Toggle `i_lcd_reg[31]` with no EN activity -> `o_lcd_on` follows 1 cycle later; no EN pulse.
